// File: rtl/conv_norm_pkg.sv
// Shared types and helpers for the conv_norm_seq convolution sequencer.
package conv_norm_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_WAIT,
      ST_CONV,
      ST_DRAIN,
      ST_STOP
   } state_t;

   localparam int KERNEL_WORDS = 10;

   // Clamp a signed value to the range of a width-bit signed number.
   function automatic logic signed [63:0] sat_dw(input logic signed [63:0] value,
                                                 input int width);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (width - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (value > hi) return hi;
      if (value < lo) return lo;
      return value;
   endfunction

endpackage

// File: rtl/conv_norm_stage.sv
// Two-stage normaliser: y = sat((x - mean) * scale >>> FRAC).
// CONV_NORM_SAT_EN selects clamping with a sticky ovf flag; otherwise the result wraps.
module conv_norm_stage
   import conv_norm_pkg::*;
#(
   parameter int DW   = 16,
   parameter int CH_W = 2,
   parameter int FRAC = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 valid,
   input  logic signed [DW-1:0] x,
   input  logic signed [DW-1:0] mean,
   input  logic signed [DW-1:0] scale,
   input  logic [CH_W-1:0]      ch,
   output logic [DW-1:0]        y,
   output logic                 y_valid,
   output logic [CH_W-1:0]      y_ch,
   output logic                 ovf
);

   logic signed [DW:0]   d_r;
   logic signed [DW-1:0] scale_r;
   logic                 v_r;
   logic [CH_W-1:0]      ch_r;
   logic signed [2*DW:0] prod;
   logic [DW-1:0]        y_n;
   logic                 clamp;
`ifdef CONV_NORM_SAT_EN
   logic signed [63:0]   wide;
   logic signed [63:0]   sat;
`endif

   always_comb begin
      prod = (2*DW+1)'(d_r) * (2*DW+1)'(scale_r);
`ifdef CONV_NORM_SAT_EN
      wide  = 64'(prod) >>> FRAC;
      sat   = sat_dw(wide, DW);
      y_n   = sat[DW-1:0];
      clamp = (sat != wide);
`else
      y_n   = DW'(prod >>> FRAC);
      clamp = 1'b0;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         d_r     <= '0;
         scale_r <= '0;
         v_r     <= 1'b0;
         ch_r    <= '0;
         y       <= '0;
         y_valid <= 1'b0;
         y_ch    <= '0;
         ovf     <= 1'b0;
      end else begin
         v_r     <= valid;
         y_valid <= v_r;
         if (valid) begin
            d_r     <= {x[DW-1], x} - {mean[DW-1], mean};
            scale_r <= scale;
            ch_r    <= ch;
         end
         // y and y_ch hold between results
         if (v_r) begin
            y    <= y_n;
            y_ch <= ch_r;
            if (clamp) ovf <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/conv_norm_seq.sv
// Multi-kernel convolution sequencer with per-channel output normalisation.
// Build option: CONV_NORM_SAT_EN (saturate + err_ovf) vs. default wrap.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | no weights yet; first weight word starts a load
// LOAD     | writing weight bank words 0..10*NUM_CH-1
// WAIT     | weights valid; waiting for a frame start or a reload
// CONV     | forwarding N*N pixels to the engine, counting results
// DRAIN    | waiting for all (N-2)^2 results to leave the normaliser
// STOP     | frame_done pulse, advance to next kernel set
//
// eng_weights word i (w11..w33, bias) sits at bits [i*DW +: DW].
module conv_norm_seq
   import conv_norm_pkg::*;
#(
   parameter int DW     = 16,
   parameter int NUM_CH = 4,
   parameter int SIZE_W = 9,
   parameter int FRAC   = 8,
   parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                       sys_clk,
   input  logic                       sys_rst,
   input  logic [SIZE_W-1:0]          image_size,
   input  logic                       pi_weight_valid,
   input  logic [DW-1:0]              pi_weight,
   input  logic                       pi_data_valid,
   input  logic [DW-1:0]              pi_data,
   input  logic [NUM_CH*DW-1:0]       mean,
   input  logic [NUM_CH*DW-1:0]       scale,
   output logic [DW-1:0]              eng_data,
   output logic                       eng_data_valid,
   output logic [KERNEL_WORDS*DW-1:0] eng_weights,
   input  logic [DW-1:0]              eng_result,
   input  logic                       eng_result_valid,
   output logic [DW-1:0]              map_out,
   output logic                       map_out_valid,
   output logic [CH_W-1:0]            map_out_ch,
   output logic                       frame_done,
   output logic                       busy,
   output logic                       err_size,
   output logic                       err_ovf
);

   localparam int TOTAL = KERNEL_WORDS * NUM_CH;
   localparam int WC_W  = $clog2(TOTAL + 1);
   localparam int CNT_W = 2 * SIZE_W;

   state_t                     state;
   logic [WC_W-1:0]            word_cnt;
   logic [TOTAL*DW-1:0]        bank;
   logic                       weights_ready;
   logic [CH_W-1:0]            ch_idx;
   logic [CH_W-1:0]            ch_nxt;
   logic [CH_W-1:0]            ch_sel;
   logic [SIZE_W-1:0]          n_lat;
   logic [CNT_W-1:0]           pix_cnt;
   logic [CNT_W-1:0]           res_cnt;
   logic [CNT_W-1:0]           pix_last;
   logic [CNT_W-1:0]           res_total;
   logic                       rv_d1;
   logic [DW-1:0]              mean_c;
   logic [DW-1:0]              scale_c;
   logic [KERNEL_WORDS*DW-1:0] w_sel;

   always_comb begin
      ch_nxt    = (ch_idx == CH_W'(NUM_CH - 1)) ? '0 : ch_idx + CH_W'(1);
      // in STOP the output register picks up the next channel's kernel
      ch_sel    = (state == ST_STOP) ? ch_nxt : ch_idx;
      w_sel     = bank[ch_sel*KERNEL_WORDS*DW +: KERNEL_WORDS*DW];
      mean_c    = mean[ch_idx*DW +: DW];
      scale_c   = scale[ch_idx*DW +: DW];
      pix_last  = CNT_W'(n_lat) * CNT_W'(n_lat) - CNT_W'(1);
      res_total = CNT_W'(n_lat - SIZE_W'(2)) * CNT_W'(n_lat - SIZE_W'(2));
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state          <= ST_IDLE;
         word_cnt       <= '0;
         bank           <= '0;
         weights_ready  <= 1'b0;
         ch_idx         <= '0;
         n_lat          <= '0;
         pix_cnt        <= '0;
         res_cnt        <= '0;
         rv_d1          <= 1'b0;
         eng_data       <= '0;
         eng_data_valid <= 1'b0;
         eng_weights    <= '0;
         frame_done     <= 1'b0;
         busy           <= 1'b0;
         err_size       <= 1'b0;
      end else begin
         eng_data_valid <= 1'b0;
         frame_done     <= 1'b0;
         rv_d1          <= eng_result_valid;
         if (state != ST_CONV && state != ST_DRAIN) eng_weights <= w_sel;

         case (state)
            ST_IDLE: begin
               if (pi_weight_valid) begin
                  bank[DW-1:0] <= pi_weight;
                  word_cnt     <= WC_W'(1);
                  state        <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               if (pi_weight_valid && word_cnt < WC_W'(TOTAL)) begin
                  bank[word_cnt*DW +: DW] <= pi_weight;
                  word_cnt                <= word_cnt + WC_W'(1);
                  if (word_cnt == WC_W'(TOTAL - 1)) weights_ready <= 1'b1;
               end
               if (weights_ready && !pi_weight_valid) state <= ST_WAIT;
            end
            ST_WAIT: begin
               // a weight word here restarts the load with itself as word 0
               if (pi_weight_valid) begin
                  weights_ready <= 1'b0;
                  err_size      <= 1'b0;
                  ch_idx        <= '0;
                  bank[DW-1:0]  <= pi_weight;
                  word_cnt      <= WC_W'(1);
                  state         <= ST_LOAD;
               end else if (pi_data_valid) begin
                  if (image_size >= SIZE_W'(3)) begin
                     n_lat          <= image_size;
                     pix_cnt        <= CNT_W'(1);
                     res_cnt        <= '0;
                     eng_data       <= pi_data;
                     eng_data_valid <= 1'b1;
                     busy           <= 1'b1;
                     state          <= ST_CONV;
                  end else begin
                     err_size <= 1'b1;
                  end
               end
            end
            ST_CONV: begin
               if (eng_result_valid) res_cnt <= res_cnt + CNT_W'(1);
               if (pi_data_valid) begin
                  eng_data       <= pi_data;
                  eng_data_valid <= 1'b1;
                  pix_cnt        <= pix_cnt + CNT_W'(1);
                  if (pix_cnt == pix_last) state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (eng_result_valid) res_cnt <= res_cnt + CNT_W'(1);
               // rv_d1 mirrors the normaliser's first stage; once it is clear
               // the last result is in the output register this cycle
               if (res_cnt >= res_total && !rv_d1) begin
                  frame_done <= 1'b1;
                  busy       <= 1'b0;
                  state      <= ST_STOP;
               end
            end
            ST_STOP: begin
               ch_idx <= ch_nxt;
               state  <= ST_WAIT;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   conv_norm_stage #(
      .DW   (DW),
      .CH_W (CH_W),
      .FRAC (FRAC)
   ) u_stage (
      .clk     (sys_clk),
      .rst     (sys_rst),
      .valid   (eng_result_valid),
      .x       (eng_result),
      .mean    (mean_c),
      .scale   (scale_c),
      .ch      (ch_idx),
      .y       (map_out),
      .y_valid (map_out_valid),
      .y_ch    (map_out_ch),
      .ovf     (err_ovf)
   );

endmodule

// File: tb/tb_conv_norm_seq.sv
// Scoreboard bench for conv_norm_seq with NUM_CH=2 and a simple 3x3 engine model.
module tb_conv_norm_seq;
   import conv_norm_pkg::*;

   localparam int DW     = 16;
   localparam int NUM_CH = 2;
   localparam int CH_W   = 1;
   localparam int SIZE_W = 9;
   localparam int FRAC   = 8;
   localparam int KW     = KERNEL_WORDS;

   logic                 sys_clk;
   logic                 sys_rst;
   logic [SIZE_W-1:0]    image_size;
   logic                 pi_weight_valid;
   logic [DW-1:0]        pi_weight;
   logic                 pi_data_valid;
   logic [DW-1:0]        pi_data;
   logic [NUM_CH*DW-1:0] mean;
   logic [NUM_CH*DW-1:0] scale;
   logic [DW-1:0]        eng_data;
   logic                 eng_data_valid;
   logic [KW*DW-1:0]     eng_weights;
   logic [DW-1:0]        eng_result;
   logic                 eng_result_valid;
   logic [DW-1:0]        map_out;
   logic                 map_out_valid;
   logic [CH_W-1:0]      map_out_ch;
   logic                 frame_done;
   logic                 busy;
   logic                 err_size;
   logic                 err_ovf;

   conv_norm_seq #(.DW(DW), .NUM_CH(NUM_CH), .SIZE_W(SIZE_W), .FRAC(FRAC)) dut (
      .sys_clk          (sys_clk),
      .sys_rst          (sys_rst),
      .image_size       (image_size),
      .pi_weight_valid  (pi_weight_valid),
      .pi_weight        (pi_weight),
      .pi_data_valid    (pi_data_valid),
      .pi_data          (pi_data),
      .mean             (mean),
      .scale            (scale),
      .eng_data         (eng_data),
      .eng_data_valid   (eng_data_valid),
      .eng_weights      (eng_weights),
      .eng_result       (eng_result),
      .eng_result_valid (eng_result_valid),
      .map_out          (map_out),
      .map_out_valid    (map_out_valid),
      .map_out_ch       (map_out_ch),
      .frame_done       (frame_done),
      .busy             (busy),
      .err_size         (err_size),
      .err_ovf          (err_ovf)
   );

   typedef struct {
      logic [DW-1:0]   val;
      logic [CH_W-1:0] ch;
      int              cyc;
   } res_t;

   typedef struct {
      logic [DW-1:0] val;
      int            cyc;
   } pix_t;

   res_t res_q[$];
   pix_t pix_q[$];
   res_t r_item;
   pix_t p_item;

   int checks = 0;
   int passed = 0;
   int cyc = 0;
   int done_cnt = 0;
   int res_seen = 0;
   int dv_seen = 0;
   int last_mov = -10;

   // engine model controls
   logic [DW-1:0]   eng_x = '0;
   logic [DW-1:0]   exp_val = '0;
   logic [CH_W-1:0] exp_ch = '0;
   int              n_cur = 4;
   int              eng_cnt = 0;

   logic [KW*DW-1:0] exp_w0;
   logic [KW*DW-1:0] exp_w1;

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;
   always @(posedge sys_clk) cyc <= cyc + 1;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic check_w(input string name, input logic [KW*DW-1:0] act,
                          input logic [KW*DW-1:0] exp);
      checks++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic send_weights();
      for (int c = 0; c < NUM_CH; c++) begin
         for (int i = 0; i < KW; i++) begin
            pi_weight_valid = 1'b1;
            if (i == KW - 1) pi_weight = (c == 0) ? 16'd0 : 16'd5;
            else             pi_weight = (c == 0) ? 16'd1 : 16'd2;
            tick();
         end
      end
      pi_weight_valid = 1'b0;
      pi_weight       = '0;
   endtask

   task automatic send_pixel(input logic [DW-1:0] v, input bit expect_fwd);
      pi_data_valid = 1'b1;
      pi_data       = v;
      if (expect_fwd) pix_q.push_back('{v, cyc + 1});
      tick();
      pi_data_valid = 1'b0;
   endtask

   task automatic run_frame(input int n, input bit gaps);
      for (int p = 0; p < n * n; p++) begin
         send_pixel(DW'(p + 1), 1'b1);
         if (gaps) repeat ($urandom_range(0, 2)) tick();
      end
   endtask

   task automatic wait_frame(input string name);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge sys_clk);
         if (dut.state == ST_WAIT && res_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      check(name, longint'(ok), 1);
   endtask

   // engine: one result per complete 3x3 window, issued with the pixel that completes it
   initial begin
      eng_result_valid = 1'b0;
      eng_result       = '0;
      forever begin
         @(posedge sys_clk);
         #1;
         eng_result_valid = 1'b0;
         if (sys_rst) begin
            eng_cnt = 0;
         end else if (eng_data_valid) begin
            if (eng_cnt / n_cur >= 2 && eng_cnt % n_cur >= 2) begin
               eng_result_valid = 1'b1;
               eng_result       = eng_x;
               res_q.push_back('{exp_val, exp_ch, cyc + 2});
            end
            eng_cnt++;
            if (eng_cnt == n_cur * n_cur) eng_cnt = 0;
         end
      end
   end

   // monitor
   initial begin
      forever begin
         @(negedge sys_clk);
         if (eng_data_valid) begin
            dv_seen++;
            if (pix_q.size() == 0) begin
               check("eng_data_expected", pix_q.size(), 1);
            end else begin
               p_item = pix_q.pop_front();
               check("eng_data", eng_data, p_item.val);
               check("eng_data_latency", cyc, p_item.cyc);
            end
         end
         if (map_out_valid) begin
            res_seen++;
            last_mov = cyc;
            if (res_q.size() == 0) begin
               check("map_out_expected", res_q.size(), 1);
            end else begin
               r_item = res_q.pop_front();
               check("map_out", map_out, r_item.val);
               check("map_out_ch", map_out_ch, r_item.ch);
               check("map_out_latency", cyc, r_item.cyc);
            end
         end
         if (frame_done) begin
            done_cnt++;
            check("frame_done_timing", cyc - last_mov, 1);
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL timeout: simulation did not finish, checks so far %0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      int d0, r0, v0;
      for (int i = 0; i < KW; i++) begin
         exp_w0[i*DW +: DW] = (i == KW - 1) ? 16'd0 : 16'd1;
         exp_w1[i*DW +: DW] = (i == KW - 1) ? 16'd5 : 16'd2;
      end
      sys_rst         = 1'b1;
      image_size      = 9'd4;
      pi_weight_valid = 1'b0;
      pi_weight       = '0;
      pi_data_valid   = 1'b0;
      pi_data         = '0;
      mean            = {16'd0, 16'd20};
      scale           = {16'h0200, 16'h0100};

      // reset state
      repeat (3) tick();
      @(negedge sys_clk);
      check("reset_outputs", {eng_data_valid, map_out_valid, frame_done, busy, err_size,
                              err_ovf, eng_data, map_out, map_out_ch}, 0);
      check_w("reset_weights", eng_weights, '0);
      check("reset_state", longint'(dut.state), longint'(ST_IDLE));
      tick();
      sys_rst = 1'b0;
      tick();

      // load both kernel sets
      send_weights();
      tick();
      tick();
      @(negedge sys_clk);
      check("load_state_wait", longint'(dut.state), longint'(ST_WAIT));
      check("weights_ready", dut.weights_ready, 1);
      check_w("weights_ch0", eng_weights, exp_w0);

      // frame 1: channel 0, (100-20)*1.0 = 80
      eng_x = 16'd100; exp_val = 16'd80; exp_ch = 1'b0; n_cur = 4;
      tick();
      r0 = res_seen;
      run_frame(4, 1'b0);
      @(negedge sys_clk);
      check("busy_in_drain", busy, 1);
      check_w("weights_stable", eng_weights, exp_w0);
      wait_frame("frame1_complete");
      check("frame1_results", res_seen - r0, 4);
      check("frame1_done", done_cnt, 1);
      check("frame1_ch_next", dut.ch_idx, 1);
      check_w("weights_ch1", eng_weights, exp_w1);
      check("frame1_busy_low", busy, 0);

      // frame 2: channel 1, (50-0)*2.0 = 100; channel then wraps
      eng_x = 16'd50; exp_val = 16'd100; exp_ch = 1'b1;
      tick();
      r0 = res_seen;
      run_frame(4, 1'b0);
      wait_frame("frame2_complete");
      check("frame2_results", res_seen - r0, 4);
      check("frame2_done", done_cnt, 2);
      check("frame2_ch_wrap", dut.ch_idx, 0);
      check_w("weights_ch0_again", eng_weights, exp_w0);
      check("no_ovf_yet", err_ovf, 0);

      // frame 3: (30000 - -30000)*1.0 = 60000, out of 16-bit range
      mean[DW-1:0] = -16'sd30000;
      eng_x = 16'd30000; exp_ch = 1'b0;
`ifdef CONV_NORM_SAT_EN
      exp_val = 16'd32767;
`else
      exp_val = 16'hEA60;
`endif
      tick();
      run_frame(4, 1'b0);
      wait_frame("frame3_complete");
`ifdef CONV_NORM_SAT_EN
      check("err_ovf_set", err_ovf, 1);
`else
      check("err_ovf_wrap_zero", err_ovf, 0);
`endif
      check("frame3_ch_next", dut.ch_idx, 1);
      mean[DW-1:0] = 16'd20;

      // undersized frame: pixels dropped, err_size sticky
      image_size = 9'd2;
      v0 = dv_seen;
      tick();
      for (int i = 0; i < 3; i++) send_pixel(DW'(i + 7), 1'b0);
      tick();
      @(negedge sys_clk);
      check("err_size_set", err_size, 1);
      check("err_size_no_fwd", dv_seen - v0, 0);
      check("err_size_state", longint'(dut.state), longint'(ST_WAIT));

      // reload clears err_size and channel index
      image_size = 9'd4;
      tick();
      send_weights();
      tick();
      tick();
      @(negedge sys_clk);
      check("reload_err_size", err_size, 0);
      check("reload_ch", dut.ch_idx, 0);
      check("reload_state", longint'(dut.state), longint'(ST_WAIT));
      check_w("reload_weights", eng_weights, exp_w0);

      // reset mid-CONV: abort before any result is produced
      eng_x = 16'd100; exp_val = 16'd80; exp_ch = 1'b0;
      tick();
      d0 = done_cnt;
      for (int i = 0; i < 6; i++) send_pixel(DW'(i + 1), 1'b1);
      @(negedge sys_clk);
      check("busy_mid_conv", busy, 1);
      #1 sys_rst = 1'b1;
      @(negedge sys_clk);
      check("abort_outputs", {eng_data_valid, map_out_valid, frame_done, busy, err_size,
                              err_ovf, eng_data, map_out, map_out_ch}, 0);
      check_w("abort_weights", eng_weights, '0);
      check("abort_state", longint'(dut.state), longint'(ST_IDLE));
      tick();
      sys_rst = 1'b0;
      repeat (10) tick();
      check("abort_no_done", done_cnt - d0, 0);
      check("abort_queues", res_q.size() + pix_q.size(), 0);

      // frame with pixel gaps gives the same result count
      send_weights();
      tick();
      tick();
      r0 = res_seen;
      run_frame(4, 1'b1);
      wait_frame("gap_frame_complete");
      check("gap_results", res_seen - r0, 4);
      check("gap_done", done_cnt - d0, 1);

      repeat (3) tick();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
